div_request_scheduler: RTL and testbench

//  Upstream/downstream shell around the signed algorithmic divider (CLK/RSTa, Start/Done, Num/Den -> Coc/Res).

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_op_fifo.sv | 50 +++++
 rtl/div_request_scheduler.sv | 156 +++++++++++++++
 tb/tb_div_request_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider request scheduler: FSM states, default
// widths and the request record carried through the operand FIFO.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_OUT
    } sched_state_e;

    localparam int DIV_W      = 32;
    localparam int DIV_TAG_W  = 4;
    localparam int DIV_DEPTH  = 4;
    localparam int DIV_PTR_W  = $clog2(DIV_DEPTH);

    typedef struct packed {
        logic [DIV_W-1:0]     num;
        logic [DIV_W-1:0]     den;
        logic [DIV_TAG_W-1:0] tag;
    } div_req_t;

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO with full/empty flags; the element type is a
// type parameter so the scheduler can pass its own width-matched record.
module div_op_fifo
    import div_pkg::*;
#(
    parameter type T     = div_req_t,
    parameter int  DEPTH = DIV_DEPTH
) (
    input  logic CLK,
    input  logic RSTa,
    input  logic wr_en,
    input  T     wr_data,
    input  logic rd_en,
    output T     rd_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_wr;
    logic           do_rd;

    // A write into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rd_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/div_request_scheduler.sv
// Queues tagged operand pairs and runs them one at a time through the divider.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor bypasses the divider with an error result.
module div_request_scheduler
    import div_pkg::*;
#(
    parameter int tamanyo = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [tamanyo-1:0] in_num,
    input  logic [tamanyo-1:0] in_den,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               div_start,
    output logic [tamanyo-1:0] div_num,
    output logic [tamanyo-1:0] div_den,
    input  logic               div_done,
    input  logic [tamanyo-1:0] div_coc,
    input  logic [tamanyo-1:0] div_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [tamanyo-1:0] out_coc,
    output logic [tamanyo-1:0] out_res,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [tamanyo-1:0] num;
        logic [tamanyo-1:0] den;
        logic [TAG_W-1:0]   tag;
    } req_t;

    sched_state_e       state;
    sched_state_e       state_nxt;
    logic [TMR_W-1:0]   timer;
    logic               timed_out;
    logic               pop;
    logic               zero_den;
    logic               fifo_full;
    logic               fifo_empty;
    req_t               wr_req;
    req_t               head;
    logic [TAG_W-1:0]   op_tag;

    assign wr_req   = '{num: in_num, den: in_den, tag: in_tag};
    assign in_ready = !fifo_full;

    div_op_fifo #(
        .T     (req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RSTa    (RSTa),
        .wr_en   (in_valid && in_ready),
        .wr_data (wr_req),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef DIV_ZERO_CHECK_EN
    assign zero_den = (head.den == '0);
`else
    assign zero_den = 1'b0;
`endif

    assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        div_start = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = zero_den ? S_OUT : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                div_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_done || timed_out) state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand registers feed the divider directly and move only on a pop;
    // a Done arriving outside S_WAIT (e.g. after a timeout) is never sampled.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            div_num <= '0;
            div_den <= '0;
            op_tag  <= '0;
            timer   <= '0;
            out_coc <= '0;
            out_res <= '0;
            out_tag <= '0;
            out_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        div_num <= head.num;
                        div_den <= head.den;
                        op_tag  <= head.tag;
                        if (zero_den) begin
                            out_coc <= '1;
                            out_res <= head.num;
                            out_tag <= head.tag;
                            out_err <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: timer <= '0;
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (div_done) begin
                        out_coc <= div_coc;
                        out_res <= div_res;
                        out_tag <= op_tag;
                        out_err <= 1'b0;
                    end else if (timed_out) begin
                        out_coc <= '0;
                        out_res <= '0;
                        out_tag <= op_tag;
                        out_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_request_scheduler.sv
// Directed bench for div_request_scheduler with a behavioural fixed-latency divider.
module tb_div_request_scheduler;

    localparam int W    = 32;
    localparam int TW   = 4;
    localparam int TO   = 40;
    localparam int DLAT = 6;

    logic          CLK = 1'b0;
    logic          RSTa = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_num = '0;
    logic [W-1:0]  in_den = '0;
    logic [TW-1:0] in_tag = '0;
    logic          div_start;
    logic [W-1:0]  div_num;
    logic [W-1:0]  div_den;
    logic          div_done = 1'b0;
    logic [W-1:0]  div_coc = '0;
    logic [W-1:0]  div_res = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_coc;
    logic [W-1:0]  out_res;
    logic [TW-1:0] out_tag;
    logic          out_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    bit hang = 1'b0;
    bit force_done = 1'b0;

    logic [W-1:0] m_num;
    logic [W-1:0] m_den;
    int           m_cnt = 0;
    bit           m_busy = 1'b0;

    always #5 CLK = ~CLK;

    div_request_scheduler #(
        .tamanyo (W),
        .DEPTH   (4),
        .TAG_W   (TW),
        .TIMEOUT (TO)
    ) dut (
        .CLK       (CLK),
        .RSTa      (RSTa),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .in_tag    (in_tag),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_done  (div_done),
        .div_coc   (div_coc),
        .div_res   (div_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coc   (out_coc),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    // Divider model: Done DLAT cycles after Start unless hang is set.
    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        div_done <= 1'b0;
        if (!RSTa) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (div_start) begin
                m_busy    <= 1'b1;
                m_cnt     <= DLAT;
                m_num     <= div_num;
                m_den     <= div_den;
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end else if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    if (!hang) begin
                        div_done <= 1'b1;
                        if (m_den == '0) begin
                            div_coc <= '1;
                            div_res <= m_num;
                        end else begin
                            div_coc <= $signed(m_num) / $signed(m_den);
                            div_res <= $signed(m_num) % $signed(m_den);
                        end
                    end
                end
            end
            if (force_done) begin
                div_done <= 1'b1;
                div_coc  <= 32'h0BAD0BAD;
                div_res  <= 32'h0000BEEF;
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d, input logic [TW-1:0] t);
        int k;
        in_num   = n;
        in_den   = d;
        in_tag   = t;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (!in_ready) chk("send_ready", 32'(in_ready), 1);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge CLK);
            k++;
        end
        chk("out_valid_wait", 32'(out_valid), 1);
    endtask

    task automatic recv(input string tag, input logic [W-1:0] coc, input logic [W-1:0] res,
                        input logic [TW-1:0] t, input logic err);
        wait_out();
        chk({tag, "_coc"}, out_coc, coc);
        chk({tag, "_res"}, out_res, res);
        chk({tag, "_tag"}, 32'(out_tag), 32'(t));
        chk({tag, "_err"}, 32'(out_err), 32'(err));
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int s;
        int k;
        int elapsed;
        bit stable;
        logic [W-1:0] b_coc [5];
        logic [W-1:0] b_res [5];
        b_coc = '{32'd3, 32'd6, 32'd10, 32'd13, 32'd16};
        b_res = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2};

        repeat (2) @(negedge CLK);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_out_coc",   out_coc, 0);
        chk("rst_out_err",   32'(out_err), 0);
        RSTa = 1'b1;
        @(negedge CLK);

        // Single operation
        s = start_cnt;
        send(100, 7, 3);
        recv("single", 14, 2, 3, 1'b0);
        chk("single_starts", start_cnt - s, 1);

        // Signed operands
        send(-100, 7, 1);
        recv("neg_num", -14, -2, 1, 1'b0);
        send(100, -7, 2);
        recv("neg_den", -14, 2, 2, 1'b0);

        // Burst into a stalled consumer
        s = start_cnt;
        for (int t = 0; t < 5; t++) send((t + 1) * 10, 3, TW'(t));
        chk("burst_full", 32'(in_ready), 0);
        for (int t = 0; t < 5; t++) recv($sformatf("burst%0d", t), b_coc[t], b_res[t], TW'(t), 1'b0);
        chk("burst_starts", start_cnt - s, 5);

        // Backpressure hold
        send(77, 5, 9);
        wait_out();
        s = start_cnt;
        stable = 1'b1;
        repeat (50) begin
            @(negedge CLK);
            if (out_valid !== 1'b1 || out_coc !== 32'd15 || out_res !== 32'd2 ||
                out_tag !== 4'd9 || out_err !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        chk("bp_no_start", start_cnt - s, 0);
        recv("bp", 15, 2, 9, 1'b0);

        // Reset while waiting on the divider, with a second request queued
        s = start_cnt;
        send(100, 7, 1);
        send(20, 4, 2);
        k = 0;
        while (start_cnt == s && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("rst_mid_started", start_cnt - s, 1);
        repeat (2) @(negedge CLK);
        RSTa = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_in_ready",  32'(in_ready), 1);
        chk("rst_mid_out_coc",   out_coc, 0);
        chk("rst_mid_out_res",   out_res, 0);
        chk("rst_mid_div_num",   div_num, 0);
        @(negedge CLK);
        RSTa = 1'b1;
        s = start_cnt;
        repeat (20) @(negedge CLK);
        chk("rst_mid_idle_starts", start_cnt - s, 0);
        chk("rst_mid_idle_valid",  32'(out_valid), 0);
        send(63, 8, 4);
        recv("after_rst", 7, 7, 4, 1'b0);

        // Timeout, then a late Done that must be ignored
        hang = 1'b1;
        send(55, 5, 6);
        wait_out();
        elapsed = cyc - start_cyc;
        chk("to_latency", 32'((elapsed >= TO) && (elapsed <= TO + 1)), 1);
        chk("to_err", 32'(out_err), 1);
        chk("to_coc", out_coc, 0);
        force_done = 1'b1;
        @(negedge CLK);
        force_done = 1'b0;
        @(negedge CLK);
        recv("to_late_done", 0, 0, 6, 1'b1);
        hang = 1'b0;
        send(-9, 2, 7);
        recv("after_to", -4, -1, 7, 1'b0);

`ifdef DIV_ZERO_CHECK_EN
        s = start_cnt;
        send(9, 0, 5);
        recv("dz", 32'hFFFFFFFF, 9, 5, 1'b1);
        chk("dz_no_start", start_cnt - s, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
